alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational `alu` instance between `NUM_REQ` requesters, such as the integer execute path and an address/CSR helper path. Each requester presents `input0`/`input1`/`aluselect` with a valid/ready handshake. A round-robin arbiter picks one request per cycle, routes it to the shared ALU and captures `alu_out` into a one-entry response register. The response is tagged with the requester index. The block sits between issue logic and the single `alu` instance in the execute stage.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match the attached `alu`.
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester index (derived, not overridden).

- `clk` in 1 — the single clock; all state is updated on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in NUM_REQ — per-requester request valid.
- `req_ready` out NUM_REQ — per-requester accept; combinational from grant and space.
- `req_input0` in NUM_REQ*DATA_WIDTH — packed operand 0; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_input1` in NUM_REQ*DATA_WIDTH — packed operand 1; same packing as `req_input0`.
- `req_aluselect` in NUM_REQ*4 — packed ALU opcode; requester i occupies [i*4 +: 4].
- `alu_input0` out DATA_WIDTH — to shared `alu.input0`.
- `alu_input1` out DATA_WIDTH — to shared `alu.input1`.
- `alu_aluselect` out 4 — to shared `alu.aluselect`.
- `alu_out` in DATA_WIDTH — from shared `alu.out`.
- `rsp_valid` out 1 — response register holds a result.
- `rsp_ready` in 1 — consumer accepts the response.
- `rsp_id` out ID_W — index of the requester that owns the response.
- `rsp_data` out DATA_WIDTH — registered ALU result.

## Operation
- **Response register FSM, two states:**
  - `EMPTY`: `rsp_valid`=0.
  - `FULL`: `rsp_valid`=1.
- **Space:** `can_accept = (state==EMPTY) || rsp_ready`.
- **Arbitration:**
  - Round-robin with pointer `rr_ptr` (ID_W bits).
  - Search order is `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ. The first asserted `req_valid` in that order wins.
  - At most one grant per cycle (one-hot).
  - `req_ready[i] = grant[i] && can_accept`.
- **Transfer:** a transfer for requester i occurs when `req_valid[i] && req_ready[i]`.
  - On the clock edge, `rsp_data <= alu_out`, `rsp_id <= i`, `state <= FULL`.
  - On the same edge, `rr_ptr <= (i+1) mod NUM_REQ`.
- **No transfer:** if there is no transfer and `rsp_valid && rsp_ready`, then `state <= EMPTY`.
  - `rsp_data` and `rsp_id` hold their last values.
- **Pointer hold:** `rr_ptr` changes only on a transfer. A stalled grant does not rotate priority.
- **ALU drive:**
  - When any request is valid, the `alu_*` outputs carry the winner's fields every cycle, whether or not `can_accept` is high.
  - With no valid request, the `alu_*` outputs are driven to 0 (opcode 0 = add 0+0).
- **Opcode passthrough:** `aluselect` values are passed unmodified. Undefined opcodes yield whatever `alu` returns (0). The arbiter does not check them.
- **Requester obligation:** while `req_valid[i]`=1 and `req_ready[i]`=0, requester i must hold its fields stable and must not drop valid.
- **Grant may move between cycles:** while `can_accept`=0, the combinational grant follows the current `req_valid` set. A newly valid lower-index requester does not preempt a held request unless it precedes it in round-robin order from `rr_ptr`.
- **Simultaneous drain and refill:** when FULL, `rsp_ready`=1 and a request is valid in the same cycle, the old response is consumed and the new one is loaded on the same edge. The state stays FULL.
- **Arithmetic:** `rr_ptr+1` wraps modulo NUM_REQ; for NUM_REQ=3, 2→0. No width change occurs on data.

## Timing
- **Reset** (asynchronous assert, synchronous-to-`clk` release by the system):
  - `state`=EMPTY, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rr_ptr`=0.
  - `req_ready`=0 while `rst_n`=0.
  - `alu_*` outputs are 0 while `rst_n`=0.
- **Reset mid-operation:** a pending response is discarded. There is no transfer on the edge where reset is asserted.
- **Latency:** a request accepted in cycle N gives `rsp_valid`=1 with its data in cycle N+1.
- **Throughput:** one result per cycle while `rsp_ready`=1.
- **Bubble:** with `rsp_ready` held at 0, one request is accepted and then `req_ready` is all zero until drain.
- **Combinational paths:**
  - `req_valid` → `req_ready`.
  - `rsp_ready` → `req_ready`.
  - `req_*` → `alu_*`.
  - There is no combinational path from `alu_out` to any output other than through the register.

## Test plan
- **Reset then single request:** reset, then `req_valid`=01 with req0 = 5, 3, op 0 → `req_ready`=01 the same cycle. Next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8; `rr_ptr`=1.
- **Round-robin fairness:** both requesters valid continuously, `rsp_ready`=1, req0 = 10-4 (op 1), req1 = 1<<4 (op 2) → grants alternate 0,1,0,1. `rsp_data` sequence is 6, 16, 6, 16 and `rsp_id` sequence is 0, 1, 0, 1.
- **Backpressure:** `rsp_ready`=0 with both requesters valid → exactly one transfer, then `req_ready`=00 for 5 cycles while `rsp_data` is held. Raising `rsp_ready` gives a drain and refill on the same edge, with the next grant going to the other requester.
- **Stall preserves pointer:** `rr_ptr`=1, FULL, `rsp_ready`=0, only req0 valid; then req1 also becomes valid before the drain → at the drain cycle the grant goes to req1, not req0.
- **Async reset mid-burst:** assert `rst_n`=0 between edges while FULL → `rsp_valid` drops immediately, not waiting for `clk`. After release, the first transfer goes to req0.
- **NUM_REQ=3 wrap:** all three valid, op 10 (LUI passthrough) with input1 = 0x1000, 0x2000, 0x3000 → ids 0, 1, 2, 0 with matching data; `rr_ptr` wraps 2→0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between NUM_REQ
//            requesters, with a one-entry, requester-tagged response register.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
   parameter int  DATA_WIDTH = 32,
   parameter int  NUM_REQ    = 2,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_input0,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_input1,
   input  logic [NUM_REQ*4-1:0]          req_aluselect,
   output logic [DATA_WIDTH-1:0]         alu_input0,
   output logic [DATA_WIDTH-1:0]         alu_input1,
   output logic [3:0]                    alu_aluselect,
   input  logic [DATA_WIDTH-1:0]         alu_out,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] c_last    = ID_W'(NUM_REQ - 1);

   state_t                  r_state;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic [ID_W-1:0]         r_rsp_id;
   logic [ID_W-1:0]         r_rr_ptr;

   logic [DATA_WIDTH-1:0]   w_in0 [NUM_REQ];
   logic [DATA_WIDTH-1:0]   w_in1 [NUM_REQ];
   logic [3:0]              w_sel [NUM_REQ];

   logic [NUM_REQ-1:0]      w_grant;
   logic [ID_W-1:0]         w_grant_id;
   logic [ID_W:0]           w_sum;
   logic                    w_any;
   logic                    w_can_accept;
   logic                    w_xfer;
   logic [ID_W-1:0]         w_next_ptr;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_in0[g] = req_input0[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_in1[g] = req_input1[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_sel[g] = req_aluselect[g*4 +: 4];
   end

   // Search from r_rr_ptr upward, wrapping modulo NUM_REQ; first valid wins.
   always_comb begin
      w_grant    = '0;
      w_grant_id = '0;
      w_any      = 1'b0;
      w_sum      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
         end
         if (!w_any && req_valid[w_sum[ID_W-1:0]]) begin
            w_any                      = 1'b1;
            w_grant[w_sum[ID_W-1:0]]   = 1'b1;
            w_grant_id                 = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_can_accept = (r_state == S_EMPTY) || rsp_ready;
   assign w_xfer       = w_any && w_can_accept;
   assign w_next_ptr   = (w_grant_id == c_last) ? '0 : w_grant_id + ID_W'(1);
   assign req_ready    = rst_n ? (w_grant & {NUM_REQ{w_can_accept}}) : '0;

   always_comb begin
      alu_input0    = '0;
      alu_input1    = '0;
      alu_aluselect = '0;
      if (rst_n && w_any) begin
         alu_input0    = w_in0[w_grant_id];
         alu_input1    = w_in1[w_grant_id];
         alu_aluselect = w_sel[w_grant_id];
      end
   end

   // A transfer reloads the register even when FULL, covering drain-and-refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_EMPTY;
         r_rsp_data <= '0;
         r_rsp_id   <= '0;
         r_rr_ptr   <= '0;
      end else if (w_xfer) begin
         r_state    <= S_FULL;
         r_rsp_data <= alu_out;
         r_rsp_id   <= w_grant_id;
         r_rr_ptr   <= w_next_ptr;
      end else if ((r_state == S_FULL) && rsp_ready) begin
         r_state    <= S_EMPTY;
      end
   end

   assign rsp_valid = (r_state == S_FULL);
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter (NUM_REQ=2 and NUM_REQ=3).
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

   logic clk;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   // Reference behaviour of the shared combinational alu for the opcodes used.
   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   // NUM_REQ = 2 instance
   logic [1:0]  v2, r2;
   logic [63:0] in0_2, in1_2;
   logic [7:0]  sel2;
   logic [31:0] a0_2, a1_2, aout2, rdata2;
   logic [3:0]  asel2;
   logic        rv2, rrdy2;
   logic [0:0]  rid2;

   assign aout2 = alu_f(a0_2, a1_2, asel2);

   alu_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v2), .req_ready(r2),
      .req_input0(in0_2), .req_input1(in1_2), .req_aluselect(sel2),
      .alu_input0(a0_2), .alu_input1(a1_2), .alu_aluselect(asel2), .alu_out(aout2),
      .rsp_valid(rv2), .rsp_ready(rrdy2), .rsp_id(rid2), .rsp_data(rdata2)
   );

   // NUM_REQ = 3 instance
   logic [2:0]  v3, r3;
   logic [95:0] in0_3, in1_3;
   logic [11:0] sel3;
   logic [31:0] a0_3, a1_3, aout3, rdata3;
   logic [3:0]  asel3;
   logic        rv3, rrdy3;
   logic [1:0]  rid3;

   assign aout3 = alu_f(a0_3, a1_3, asel3);

   alu_arbiter #(.DATA_WIDTH(32), .NUM_REQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v3), .req_ready(r3),
      .req_input0(in0_3), .req_input1(in1_3), .req_aluselect(sel3),
      .alu_input0(a0_3), .alu_input1(a1_3), .alu_aluselect(asel3), .alu_out(aout3),
      .rsp_valid(rv3), .rsp_ready(rrdy3), .rsp_id(rid3), .rsp_data(rdata3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected responses: {id[1:0], data[31:0]}
   logic [33:0] q2[$];
   logic [33:0] q3[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitors: compare each response as the consumer takes it.
   always @(negedge clk) begin : mon2
      logic [33:0] e;
      if (rst_n && rv2 && rrdy2) begin
         if (q2.size() == 0) begin
            chk("rsp2_unexpected", 64'd1, 64'd0);
         end else begin
            e = q2.pop_front();
            chk("rsp2_id", 64'(rid2), 64'(e[33:32]));
            chk("rsp2_data", 64'(rdata2), 64'(e[31:0]));
         end
      end
   end

   always @(negedge clk) begin : mon3
      logic [33:0] e;
      if (rst_n && rv3 && rrdy3) begin
         if (q3.size() == 0) begin
            chk("rsp3_unexpected", 64'd1, 64'd0);
         end else begin
            e = q3.pop_front();
            chk("rsp3_id", 64'(rid3), 64'(e[33:32]));
            chk("rsp3_data", 64'(rdata3), 64'(e[31:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      v2 = '0; rrdy2 = 1'b0; in0_2 = '0; in1_2 = '0; sel2 = '0;
      v3 = '0; rrdy3 = 1'b0; in0_3 = '0; in1_3 = '0; sel3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 64'(rv2), 64'd0);
      chk("reset_rsp_id", 64'(rid2), 64'd0);
      chk("reset_rsp_data", 64'(rdata2), 64'd0);
      v2 = 2'b11; in0_2 = {32'd9, 32'd9};
      #1;
      chk("reset_req_ready", 64'(r2), 64'd0);
      chk("reset_alu_in0", 64'(a0_2), 64'd0);
      v2 = '0; in0_2 = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Single request: 5+3 from req0
      v2 = 2'b01; in0_2 = {32'd0, 32'd5}; in1_2 = {32'd0, 32'd3}; sel2 = '0; rrdy2 = 1'b1;
      q2.push_back({2'd0, 32'd8});
      #1;
      chk("single_req_ready", 64'(r2), 64'd1);
      chk("single_alu_in0", 64'(a0_2), 64'd5);
      tick();
      chk("single_rsp_valid", 64'(rv2), 64'd1);
      chk("single_rsp_data", 64'(rdata2), 64'd8);
      v2 = '0;
      tick();

      // Fairness: pointer is now 1, so req1 (1<<4) leads, then req0 (10-4)
      v2 = 2'b11; in0_2 = {32'd1, 32'd10}; in1_2 = {32'd4, 32'd4}; sel2 = {4'd2, 4'd1};
      q2.push_back({2'd1, 32'd16});
      q2.push_back({2'd0, 32'd6});
      q2.push_back({2'd1, 32'd16});
      q2.push_back({2'd0, 32'd6});
      #1;
      chk("rr_first_grant", 64'(r2), 64'd2);
      repeat (4) tick();
      v2 = '0;
      tick();

      // Backpressure: one transfer (req1: 20-5), then a 5-cycle bubble
      rrdy2 = 1'b0; v2 = 2'b11;
      in0_2 = {32'd20, 32'd7}; in1_2 = {32'd5, 32'd2}; sel2 = {4'd1, 4'd0};
      q2.push_back({2'd1, 32'd15});
      #1;
      chk("bp_first_grant", 64'(r2), 64'd2);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_req_ready", 64'(r2), 64'd0);
         chk("bp_hold_data", 64'(rdata2), 64'd15);
         tick();
      end
      rrdy2 = 1'b1;
      q2.push_back({2'd0, 32'd9});
      #1;
      chk("bp_refill_grant", 64'(r2), 64'd1);
      tick();
      chk("bp_refill_full", 64'(rv2), 64'd1);
      chk("bp_refill_id", 64'(rid2), 64'd0);
      v2 = '0;
      tick();

      // Stall preserves pointer
      rrdy2 = 1'b0; v2 = 2'b01;
      in0_2 = {32'd0, 32'd3}; in1_2 = {32'd0, 32'd3}; sel2 = '0;
      q2.push_back({2'd0, 32'd6});
      tick();
      in0_2[31:0] = 32'd2; in1_2[31:0] = 32'd2;
      #1;
      chk("stall_ready_a", 64'(r2), 64'd0);
      tick();
      v2 = 2'b11; in0_2[63:32] = 32'd9; in1_2[63:32] = 32'd1; sel2[7:4] = 4'd1;
      #1;
      chk("stall_ready_b", 64'(r2), 64'd0);
      tick();
      rrdy2 = 1'b1;
      q2.push_back({2'd1, 32'd8});
      #1;
      chk("stall_drain_grant", 64'(r2), 64'd2);
      tick();
      v2 = 2'b01;
      q2.push_back({2'd0, 32'd4});
      #1;
      chk("stall_next_grant", 64'(r2), 64'd1);
      tick();
      v2 = '0;
      tick();

      // Async reset while FULL discards the pending response
      rrdy2 = 1'b0; v2 = 2'b10;
      in0_2[63:32] = 32'd5; in1_2[63:32] = 32'd5; sel2[7:4] = 4'd0;
      tick();
      chk("pre_reset_full", 64'(rv2), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", 64'(rv2), 64'd0);
      chk("async_rsp_data", 64'(rdata2), 64'd0);
      chk("async_req_ready", 64'(r2), 64'd0);
      v2 = 2'b11; in0_2[31:0] = 32'd1; in1_2[31:0] = 32'd2; sel2[3:0] = 4'd0;
      tick();
      rst_n = 1'b1; rrdy2 = 1'b1;
      q2.push_back({2'd0, 32'd3});
      #1;
      chk("post_reset_grant", 64'(r2), 64'd1);
      tick();
      v2 = '0;
      tick();
      chk("idle_alu_in0", 64'(a0_2), 64'd0);
      chk("idle_alu_sel", 64'(asel2), 64'd0);

      // NUM_REQ=3 wrap with LUI passthrough
      v3 = 3'b111; rrdy3 = 1'b1;
      in0_3 = {32'hdead, 32'hdead, 32'hdead};
      in1_3 = {32'h3000, 32'h2000, 32'h1000};
      sel3  = {4'd10, 4'd10, 4'd10};
      q3.push_back({2'd0, 32'h1000});
      q3.push_back({2'd1, 32'h2000});
      q3.push_back({2'd2, 32'h3000});
      q3.push_back({2'd0, 32'h1000});
      #1;
      chk("wrap_first_grant", 64'(r3), 64'd1);
      repeat (4) tick();
      v3 = '0;
      repeat (2) tick();

      chk("q2_drained", 64'(q2.size()), 64'd0);
      chk("q3_drained", 64'(q3.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
